// File: rtl/multdiv_unit.sv
// Iterative multiply/divide unit with private HI/LO registers for the Execute stage.
// It performs one shift-add or restoring shift-subtract step per cycle,
// then runs one sign-fix cycle before writing HI/LO.
module multdiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             multdivE,
   input  logic [1:0]       mdopE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic [1:0]       hiloE,
   output logic [WIDTH-1:0] hiloresultE,
   output logic             mdbusyE,
   output logic             mdstallE
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state, state_next;

   logic [CNT_W-1:0]   cnt;
   logic               is_div, sign_a, sign_b, div_zero;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH-1:0]   acc_hi, acc_lo;
   logic [WIDTH-1:0]   hi, lo;
   logic               accept, step, finish;

   // Operand decode on the request inputs
   logic               op_div, neg_a, neg_b;
   logic [WIDTH-1:0]   abs_a, abs_b;

   // Per-iteration and final-fix datapath values
   logic [WIDTH:0]     mul_sum, div_sh;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, raw_a;

   // Request decode: the magnitude is abs() only for the signed ops
   always_comb begin
      op_div = mdopE[1];
      neg_a  = ~mdopE[0] & srcaE[WIDTH-1];
      neg_b  = ~mdopE[0] & srcbE[WIDTH-1];
      abs_a  = neg_a ? -srcaE : srcaE;
      abs_b  = neg_b ? -srcbE : srcbE;
   end

   // Step and fix arithmetic
   always_comb begin
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
      div_sh   = {acc_hi, acc_lo[WIDTH-1]};
      div_ge   = (div_sh >= {1'b0, mag_b});
      div_rem  = WIDTH'(div_sh - {1'b0, mag_b});
      prod     = {acc_hi, acc_lo};
      prod_fix = (sign_a ^ sign_b) ? -prod : prod;
      quo_fix  = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
      rem_fix  = sign_a ? -acc_hi : acc_hi;
      raw_a    = sign_a ? -mag_a : mag_a;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (multdivE) state_next = RUN;
         RUN:     if (cnt == '0) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output and control strobes; hiloresultE is a plain mux on HI/LO
   always_comb begin
      accept      = 1'b0;
      step        = 1'b0;
      finish      = 1'b0;
      mdbusyE     = 1'b0;
      hiloresultE = '0;
      case (state)
         IDLE:    accept = multdivE;
         RUN:     begin step = 1'b1;   mdbusyE = 1'b1; end
         FIX:     begin finish = 1'b1; mdbusyE = 1'b1; end
         default: ;
      endcase
      mdstallE = mdbusyE & (multdivE | (hiloE == 2'b01) | (hiloE == 2'b10));
      case (hiloE)
         2'b01:   hiloresultE = hi;
         2'b10:   hiloresultE = lo;
         default: hiloresultE = '0;
      endcase
   end

   // Capture, iterate, and write HI/LO on the fix cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         is_div   <= 1'b0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         div_zero <= 1'b0;
         mag_a    <= '0;
         mag_b    <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         if (accept) begin
            cnt      <= CNT_W'(WIDTH - 1);
            is_div   <= op_div;
            sign_a   <= neg_a;
            sign_b   <= neg_b;
            div_zero <= op_div & (srcbE == '0);
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            acc_hi   <= '0;
            acc_lo   <= op_div ? abs_a : abs_b;
         end
         if (step) begin
            cnt <= cnt - 1'b1;
            if (is_div) begin
               acc_hi <= div_ge ? div_rem : div_sh[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end else begin
               acc_hi <= mul_sum[WIDTH:1];
               acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
         end
         if (finish) begin
            if (div_zero) begin
               hi <= raw_a;
               lo <= '1;
            end else if (is_div) begin
               hi <= rem_fix;
               lo <= quo_fix;
            end else begin
               hi <= prod_fix[2*WIDTH-1:WIDTH];
               lo <= prod_fix[WIDTH-1:0];
            end
         end
      end
   end

endmodule
